// File: rtl/rsi_pkg.sv
// Shared constants for the RSI price path: default widths, minimum run length
// and the feeder FSM state encoding.
package rsi_pkg;

  localparam int PRICE_W_DEF    = 16;
  localparam int RSI_W_DEF      = 8;
  localparam int MIN_PRICES_DEF = 15;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_FEED      = 3'd2;
  localparam logic [2:0] ST_GAP       = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_REPORT    = 3'd5;

  // Enum values pinned to the legacy encodings so external decode stays valid.
  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_FEED      = ST_FEED,
    S_GAP       = ST_GAP,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_REPORT    = ST_REPORT
  } feed_state_t;

endpackage

// File: rtl/price_fifo.sv
// Single-clock FIFO with a combinational head read; DEPTH must be a power of 2.
module price_fifo
  import rsi_pkg::*;
#(
  parameter int W     = PRICE_W_DEF,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("price_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push alongside it is kept even when full.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rsi_price_feeder.sv
// Buffers host prices and replays them to rsi_fsm on request, then captures the RSI.
// Optional WAIT_DONE watchdog with sticky timeout_err: define RSI_FEED_TIMEOUT_EN.
module rsi_price_feeder
  import rsi_pkg::*;
#(
  parameter int PRICE_W    = PRICE_W_DEF,
  parameter int RSI_W      = RSI_W_DEF,
  parameter int DEPTH      = 32,
  parameter int MIN_PRICES = MIN_PRICES_DEF,
  parameter int GAP        = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [PRICE_W-1:0]     wr_price,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   run,
  output logic                   busy,
  output logic                   run_err,
  output logic                   rsi_start,
  output logic [PRICE_W-1:0]     rsi_price,
  output logic                   rsi_new_price,
  input  logic                   rsi_done,
  input  logic [RSI_W-1:0]       rsi_value,
  output logic                   result_valid,
  output logic [RSI_W-1:0]       result
`ifdef RSI_FEED_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_PRICES);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  if ((GAP < 0) || (GAP > 15)) begin : g_bad_gap
    $error("rsi_price_feeder: GAP must be 0..15");
  end
  if ((MIN_PRICES < 1) || (MIN_PRICES > DEPTH)) begin : g_bad_min
    $error("rsi_price_feeder: MIN_PRICES must be 1..DEPTH");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rsi_price_feeder: TIMEOUT must be at least 1");
  end

  feed_state_t        state;
  logic [3:0]         gap_cnt;
  logic               fifo_pop;
  logic               fifo_empty;
  logic [PRICE_W-1:0] fifo_dout;

  price_fifo #(
    .W     (PRICE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_price),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty),
    .count (count)
  );

  // Pop in the same cycle the head is registered onto rsi_price.
  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      S_START: fifo_pop = 1'b1;
      S_FEED:  fifo_pop = (GAP == 0) && !fifo_empty;
      S_GAP:   fifo_pop = (gap_cnt == GAP_LAST) && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

`ifdef RSI_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tcnt <= '0;
    else if (state != S_WAIT_DONE) tcnt <= '0;
    else                           tcnt <= tcnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      busy          <= 1'b0;
      run_err       <= 1'b0;
      rsi_start     <= 1'b0;
      rsi_price     <= '0;
      rsi_new_price <= 1'b0;
      result_valid  <= 1'b0;
      result        <= '0;
`ifdef RSI_FEED_TIMEOUT_EN
      timeout_err   <= 1'b0;
`endif
    end else begin
      run_err       <= run && (state != S_IDLE);
      rsi_start     <= 1'b0;
      rsi_new_price <= 1'b0;
      result_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            if (count >= MIN_CNT) begin
              busy      <= 1'b1;
              rsi_start <= 1'b1;
              state     <= S_START;
`ifdef RSI_FEED_TIMEOUT_EN
              timeout_err <= 1'b0;
`endif
            end else begin
              run_err <= 1'b1;
            end
          end
        end
        S_START: begin
          rsi_price     <= fifo_dout;
          rsi_new_price <= 1'b1;
          state         <= S_FEED;
        end
        S_FEED: begin
          gap_cnt <= '0;
          if (GAP > 0) begin
            state <= S_GAP;
          end else if (!fifo_empty) begin
            rsi_price     <= fifo_dout;
            rsi_new_price <= 1'b1;
          end else begin
            state <= S_WAIT_DONE;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (!fifo_empty) begin
              rsi_price     <= fifo_dout;
              rsi_new_price <= 1'b1;
              state         <= S_FEED;
            end else begin
              state <= S_WAIT_DONE;
            end
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        S_WAIT_DONE: begin
          if (rsi_done) begin
            result       <= rsi_value;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= S_REPORT;
          end
`ifdef RSI_FEED_TIMEOUT_EN
          else if (tcnt == T_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
`endif
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsi_price_feeder.sv
// Bench for rsi_price_feeder: schedule-level model plus directed literal checks.
module tb_rsi_price_feeder;

  localparam int PW      = 16;
  localparam int RW      = 8;
  localparam int DEPTH   = 32;
  localparam int MINP    = 15;
  localparam int GAP     = 1;
  localparam int TIMEOUT = 1023;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [PW-1:0] wr_price;
  logic          full;
  logic [5:0]    count;
  logic          run;
  logic          busy;
  logic          run_err;
  logic          rsi_start;
  logic [PW-1:0] rsi_price;
  logic          rsi_new_price;
  logic          rsi_done;
  logic [RW-1:0] rsi_value;
  logic          result_valid;
  logic [RW-1:0] result;
`ifdef RSI_FEED_TIMEOUT_EN
  logic          timeout_err;
`endif

  rsi_price_feeder #(
    .PRICE_W    (PW),
    .RSI_W      (RW),
    .DEPTH      (DEPTH),
    .MIN_PRICES (MINP),
    .GAP        (GAP),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_price      (wr_price),
    .full          (full),
    .count         (count),
    .run           (run),
    .busy          (busy),
    .run_err       (run_err),
    .rsi_start     (rsi_start),
    .rsi_price     (rsi_price),
    .rsi_new_price (rsi_new_price),
    .rsi_done      (rsi_done),
    .rsi_value     (rsi_value),
    .result_valid  (result_valid),
    .result        (result)
`ifdef RSI_FEED_TIMEOUT_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Model: FIFO as a queue; after acceptance at edge A, strobe k lands on edge
  // A+1+(GAP+1)k while the queue is non-empty at that edge; the first edge that
  // finds it empty starts the wait for done.
  int            ecnt = 0;
  logic [PW-1:0] q[$];
  bit            m_active, m_feeding, m_waiting, m_report;
  int            m_next_dec, m_dedge;
  logic          exp_busy, exp_err, exp_start, exp_np, exp_rv, exp_tout;
  logic [PW-1:0] exp_price;
  logic [RW-1:0] exp_result;

  always @(posedge clk or negedge rst_n) begin : model
    int pre;
    if (!rst_n) begin
      q.delete();
      {m_active, m_feeding, m_waiting, m_report} = '0;
      {exp_busy, exp_err, exp_start, exp_np, exp_rv, exp_tout} = '0;
      exp_price  = '0;
      exp_result = '0;
    end else begin
      ecnt++;
      pre = q.size();
      {exp_err, exp_start, exp_np, exp_rv} = '0;
      if (!m_active) begin
        if (run) begin
          if (pre >= MINP) begin
            m_active   = 1;
            m_feeding  = 1;
            m_next_dec = ecnt + 1;
            exp_start  = 1;
            exp_busy   = 1;
            exp_tout   = 0;
          end else begin
            exp_err = 1;
          end
        end
      end else begin
        if (run) exp_err = 1;
        if (m_report) begin
          m_report = 0;
          m_active = 0;
        end else if (m_feeding) begin
          if (ecnt == m_next_dec) begin
            if (pre > 0) begin
              exp_price  = q.pop_front();
              exp_np     = 1;
              m_next_dec = ecnt + GAP + 1;
            end else begin
              m_feeding = 0;
              m_waiting = 1;
              m_dedge   = ecnt;
            end
          end
        end else if (m_waiting) begin
          if (rsi_done) begin
            exp_rv     = 1;
            exp_result = rsi_value;
            exp_busy   = 0;
            m_waiting  = 0;
            m_report   = 1;
          end
`ifdef RSI_FEED_TIMEOUT_EN
          else if (ecnt - m_dedge == TIMEOUT) begin
            exp_tout  = 1;
            exp_busy  = 0;
            m_waiting = 0;
            m_active  = 0;
          end
`endif
        end
      end
      if (wr_en && q.size() < DEPTH) q.push_back(wr_price);
    end
  end

  always @(negedge clk) begin
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("run_err", 64'(run_err), 64'(exp_err));
    chk("rsi_start", 64'(rsi_start), 64'(exp_start));
    chk("new_price", 64'(rsi_new_price), 64'(exp_np));
    chk("rsi_price", 64'(rsi_price), 64'(exp_price));
    chk("result_valid", 64'(result_valid), 64'(exp_rv));
    chk("result", 64'(result), 64'(exp_result));
`ifdef RSI_FEED_TIMEOUT_EN
    chk("timeout_err", 64'(timeout_err), 64'(exp_tout));
`endif
  end

  int            st_edge[$];
  logic [PW-1:0] st_price[$];
  bit            saw_err, saw_start, saw_rv;
  int            start_edge, rv_edge, run_edge;

  always @(negedge clk) begin
    if (rsi_new_price) begin
      st_edge.push_back(ecnt);
      st_price.push_back(rsi_price);
    end
    if (run_err) saw_err = 1;
    if (rsi_start) begin
      saw_start  = 1;
      start_edge = ecnt;
    end
    if (result_valid) begin
      saw_rv  = 1;
      rv_edge = ecnt;
    end
  end

  // Stub rsi_fsm: pulses done a fixed delay after every strobe; early pulses land
  // outside WAIT_DONE and must be ignored.
  bit         resp_en = 1;
  logic [2:0] hist = '0;
  always @(posedge clk) begin
    #2;
    hist     = {hist[1:0], rsi_new_price & resp_en};
    rsi_done = hist[2];
  end

  function automatic logic [PW-1:0] price_of(input int i);
    return (i % 2 == 0) ? PW'(100 + i / 2) : PW'(98 + (i - 1) / 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_p(input logic [PW-1:0] p);
    wr_en    = 1'b1;
    wr_price = p;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic load_seq(input int n);
    for (int i = 0; i < n; i++) push_p(price_of(i));
  endtask

  task automatic do_run();
    run_edge = ecnt + 1;
    run      = 1'b1;
    tick();
    run      = 1'b0;
  endtask

  task automatic clear_mon();
    st_edge.delete();
    st_price.delete();
    saw_err   = 0;
    saw_start = 0;
    saw_rv    = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_rv(input int lim, input string nm);
    int c = 0;
    while (!saw_rv && c < lim) begin
      tick();
      c++;
    end
    chk(nm, 64'(saw_rv), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_price  = '0;
    run       = 1'b0;
    rsi_done  = 1'b0;
    rsi_value = 8'd60;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // 20 alternating prices, done 3 cycles after last strobe.
    clear_mon();
    load_seq(20);
    chk("t1_count_loaded", 64'(count), 64'd20);
    do_run();
    wait_rv(200, "t1_rv_seen");
    chk("t1_busy_at_rv", 64'(busy), 64'd0);
    tick();
    chk("t1_strobes", 64'(st_edge.size()), 64'd20);
    chk("t1_start_lat", 64'(start_edge - run_edge), 64'd0);
    chk("t1_first_lat", 64'(st_edge[0] - run_edge), 64'd1);
    chk("t1_last_lat", 64'(st_edge[19] - run_edge), 64'd39);
    chk("t1_p0", 64'(st_price[0]), 64'd100);
    chk("t1_p1", 64'(st_price[1]), 64'd98);
    chk("t1_p2", 64'(st_price[2]), 64'd101);
    chk("t1_p19", 64'(st_price[19]), 64'd107);
    for (int k = 0; k < 20; k++) begin
      chk("t1_sched", 64'(st_edge[k] - run_edge), 64'(1 + 2 * k));
      chk("t1_order", 64'(st_price[k]), 64'(price_of(k)));
    end
    chk("t1_rv_lat", 64'(rv_edge - st_edge[19]), 64'd3);
    chk("t1_result", 64'(result), 64'd60);
    chk("t1_count_end", 64'(count), 64'd0);

    // Too few samples.
    do_reset();
    clear_mon();
    load_seq(10);
    do_run();
    tick();
    tick();
    chk("t2_run_err", 64'(saw_err), 64'd1);
    chk("t2_no_start", 64'(saw_start), 64'd0);
    chk("t2_count", 64'(count), 64'd10);

    // Overfill: 33rd push dropped.
    do_reset();
    clear_mon();
    for (int i = 0; i < 32; i++) push_p(PW'(500 + i));
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_count32", 64'(count), 64'd32);
    push_p(PW'(999));
    chk("t3_count_drop", 64'(count), 64'd32);
    do_run();
    wait_rv(300, "t3_rv_seen");
    tick();
    chk("t3_strobes", 64'(st_edge.size()), 64'd32);
    chk("t3_last_price", 64'(st_price[31]), 64'd531);

    // Second run request and extra pushes during a run.
    do_reset();
    clear_mon();
    rsi_value = 8'd42;
    load_seq(20);
    do_run();
    repeat (4) tick();
    chk("t4_no_err_yet", 64'(saw_err), 64'd0);
    run = 1'b1;
    tick();
    run = 1'b0;
    push_p(PW'(700));
    push_p(PW'(701));
    chk("t4_run_err", 64'(saw_err), 64'd1);
    wait_rv(200, "t4_rv_seen");
    tick();
    chk("t4_strobes", 64'(st_edge.size()), 64'd22);
    chk("t4_p20", 64'(st_price[20]), 64'd700);
    chk("t4_p21", 64'(st_price[21]), 64'd701);
    chk("t4_result", 64'(result), 64'd42);

    // Reset during FEED.
    do_reset();
    clear_mon();
    load_seq(20);
    do_run();
    repeat (6) tick();
    chk("t5_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_start", 64'(rsi_start), 64'd0);
    chk("t5_np", 64'(rsi_new_price), 64'd0);
    chk("t5_price", 64'(rsi_price), 64'd0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_full", 64'(full), 64'd0);
    chk("t5_rv", 64'(result_valid), 64'd0);
    chk("t5_result", 64'(result), 64'd0);
    tick();
    tick();
    rst_n  = 1'b1;
    saw_rv = 0;
    repeat (60) tick();
    chk("t5_no_result", 64'(saw_rv), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);

`ifdef RSI_FEED_TIMEOUT_EN
    // No done: watchdog aborts, next accepted run clears the flag.
    do_reset();
    clear_mon();
    resp_en = 0;
    load_seq(15);
    do_run();
    begin
      int c = 0;
      while (!timeout_err && c < 1200) begin
        tick();
        c++;
      end
    end
    chk("t6_timeout", 64'(timeout_err), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_no_rv", 64'(saw_rv), 64'd0);
    resp_en = 1;
    load_seq(15);
    do_run();
    tick();
    chk("t6_cleared", 64'(timeout_err), 64'd0);
    wait_rv(200, "t6_rv_seen");
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
